// File: rtl/slave_port.sv
// Bit-serial slave port: deserialises address/write data from the master link,
// drives one memory access, and serialises read data back MSB first.
`timescale 1ns/1ps
module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  output logic                  smemwen,
  output logic                  smemren,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RRESP} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  mode_reg, mode_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0] rdsr_reg, rdsr_next;
  logic [ADDR_WIDTH-1:0] maddr_reg, maddr_next;
  logic [DATA_WIDTH-1:0] mwdata_reg, mwdata_next;
  logic                  wen_reg, wen_next;
  logic                  ren_reg, ren_next;

  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [DATA_WIDTH-1:0] wdata_shift;
  logic [CNT_W-1:0]      cnt_inc;

  assign addr_shift  = {addr_reg[ADDR_WIDTH-2:0], swdata};
  assign wdata_shift = {wdata_reg[DATA_WIDTH-2:0], swdata};
  assign cnt_inc     = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      mode_reg   <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdsr_reg   <= '0;
      maddr_reg  <= '0;
      mwdata_reg <= '0;
      wen_reg    <= 1'b0;
      ren_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      mode_reg   <= mode_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdsr_reg   <= rdsr_next;
      maddr_reg  <= maddr_next;
      mwdata_reg <= mwdata_next;
      wen_reg    <= wen_next;
      ren_reg    <= ren_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mode_next   = mode_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdsr_next   = rdsr_reg;
    maddr_next  = maddr_reg;
    mwdata_next = mwdata_reg;
    wen_next    = 1'b0;
    ren_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        // The first address bit arrives with the first mvalid cycle.
        if (mvalid) begin
          mode_next  = smode;
          addr_next  = addr_shift;
          cnt_next   = CNT_W'(1);
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (!mvalid) begin
          state_next = IDLE;
        end else begin
          addr_next = addr_shift;
          cnt_next  = cnt_inc;
          if (cnt_reg == CNT_W'(ADDR_WIDTH - 1)) begin
            cnt_next = '0;
            if (mode_reg) begin
              state_next = WDATA;
            end else begin
              // Enable and address are registered so they are valid during RREQ.
              maddr_next = addr_shift;
              ren_next   = 1'b1;
              state_next = RREQ;
            end
          end
        end
      end
      WDATA: begin
        if (!mvalid) begin
          state_next = IDLE;
        end else begin
          wdata_next = wdata_shift;
          cnt_next   = cnt_inc;
          if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_next    = '0;
            maddr_next  = addr_reg;
            mwdata_next = wdata_shift;
            wen_next    = 1'b1;
            state_next  = WRITE;
          end
        end
      end
      WRITE: state_next = IDLE;
      RREQ:  state_next = RWAIT;
      RWAIT: begin
        rdsr_next  = smemrdata;
        cnt_next   = '0;
        state_next = RRESP;
      end
      RRESP: begin
        rdsr_next = {rdsr_reg[DATA_WIDTH-2:0], 1'b0};
        cnt_next  = cnt_inc;
        if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign svalid    = (state_reg == RRESP);
  assign srdata    = svalid & rdsr_reg[DATA_WIDTH-1];
  assign smemwen   = wen_reg;
  assign smemren   = ren_reg;
  assign smemaddr  = maddr_reg;
  assign smemwdata = mwdata_reg;

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: directed and random serial transactions checked against
// a transaction-level memory model and expected access log.
`timescale 1ns/1ps
module tb_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          swdata = 1'b0;
  logic          smode = 1'b0;
  logic          mvalid = 1'b0;
  logic          srdata;
  logic          svalid;
  logic [DW-1:0] smemrdata = '0;
  logic          smemwen;
  logic          smemren;
  logic [AW-1:0] smemaddr;
  logic [DW-1:0] smemwdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .smemrdata(smemrdata),
    .smemwen(smemwen), .smemren(smemren), .smemaddr(smemaddr), .smemwdata(smemwdata)
  );

  // Content of a location that has never been written.
  function automatic logic [7:0] dflt(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
  endfunction

  // Synchronous memory with one-cycle registered read.
  logic [7:0] mem [4096];
  bit         wr_flag [4096];
  always @(posedge clk) begin
    if (smemwen) begin
      mem[smemaddr]     <= smemwdata;
      wr_flag[smemaddr] <= 1'b1;
    end
    if (smemren) smemrdata <= wr_flag[smemaddr] ? mem[smemaddr] : dflt(smemaddr);
  end

  // Observed log: kind 0 = write, 1 = read.
  int         act_kind [$];
  logic [11:0] act_addr [$];
  logic [7:0]  act_data [$];
  logic [7:0]  act_rd [$];
  logic [7:0]  acc = '0;
  int          nbits = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      acc   = '0;
      nbits = 0;
    end else begin
      if (smemwen || smemren) begin
        checks++;
        assert (!(smemwen && smemren)) else begin
          errors++;
          $error("FAIL wen_ren_exclusive observed wen=%0b ren=%0b expected not both", smemwen, smemren);
        end
      end
      if (smemwen) begin
        act_kind.push_back(0); act_addr.push_back(smemaddr); act_data.push_back(smemwdata);
      end
      if (smemren) begin
        act_kind.push_back(1); act_addr.push_back(smemaddr); act_data.push_back(8'h00);
      end
      if (svalid) begin
        acc = {acc[6:0], srdata};
        nbits++;
        if (nbits == 8) begin
          act_rd.push_back(acc);
          nbits = 0;
        end
      end
    end
  end

  // Expected log and reference memory.
  int          exp_kind [$];
  logic [11:0] exp_addr [$];
  logic [7:0]  exp_data [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  ref_mem [int];

  function automatic logic [7:0] ref_rd(input logic [11:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One serial request; abort_at>0 drops mvalid before that bit, flip scrambles
  // smode after the first cycle, garbage adds ignored busy cycles afterwards.
  task automatic drive_req(input bit mode, input logic [11:0] a, input logic [7:0] d,
                           input int abort_at, input bit flip, input int garbage);
    logic [19:0] v;
    int n;
    bit aborted;
    v = {a, d};
    n = mode ? 20 : 12;
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (abort_at > 0 && i == abort_at) begin
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      mvalid = 1'b1;
      swdata = v[19-i];
      smode  = (i == 0 || !flip) ? mode : 1'($urandom);
    end
    if (!aborted) begin
      if (mode) begin
        exp_kind.push_back(0); exp_addr.push_back(a); exp_data.push_back(d);
        ref_mem[int'(a)] = d;
      end else begin
        exp_kind.push_back(1); exp_addr.push_back(a); exp_data.push_back(8'h00);
        exp_rd.push_back(ref_rd(a));
      end
    end
    $display("req mode=%0b addr=%03h data=%02h abort_at=%0d flip=%0b", mode, a, d, abort_at, flip);
    for (int g = 0; g < garbage; g++) begin
      @(negedge clk);
      mvalid = 1'($urandom);
      swdata = 1'($urandom);
      smode  = 1'($urandom);
    end
  endtask

  task automatic settle(input int n);
    @(negedge clk);
    mvalid = 1'b0;
    swdata = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic verify(input string tag);
    chk({tag, " ev_count"}, act_kind.size(), exp_kind.size());
    for (int i = 0; i < exp_kind.size() && i < act_kind.size(); i++) begin
      chk({tag, " ev_kind"}, act_kind[i], exp_kind[i]);
      chk({tag, " ev_addr"}, act_addr[i], exp_addr[i]);
      if (exp_kind[i] == 0) chk({tag, " ev_wdata"}, act_data[i], exp_data[i]);
    end
    chk({tag, " rd_count"}, act_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++)
      chk({tag, " rd_data"}, act_rd[i], exp_rd[i]);
    chk({tag, " partial_bits"}, nbits, 0);
    act_kind.delete(); act_addr.delete(); act_data.delete(); act_rd.delete();
    exp_kind.delete(); exp_addr.delete(); exp_data.delete(); exp_rd.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " srdata"}, srdata, 0);
    chk({tag, " svalid"}, svalid, 0);
    chk({tag, " smemwen"}, smemwen, 0);
    chk({tag, " smemren"}, smemren, 0);
    chk({tag, " smemaddr"}, smemaddr, 0);
    chk({tag, " smemwdata"}, smemwdata, 0);
  endtask

  initial begin
    logic [11:0] pool [4];
    logic [11:0] a;
    bit          m;
    int          ab;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    settle(2);

    // Write CC then read it back: srdata must be 1,1,0,0,1,1,0,0.
    drive_req(1, 12'hD4D, 8'hCC, 0, 0, 0); settle(14); verify("wr_cc");
    drive_req(0, 12'hD4D, 8'h00, 0, 0, 0); settle(14);
    if (act_rd.size() > 0) chk("plan_rd_cc", act_rd[0], 8'hCC);
    verify("rd_cc");

    drive_req(1, 12'hD4D, 8'hAA, 0, 0, 0); settle(14);
    if (act_kind.size() > 0) begin
      chk("plan_wr_addr", act_addr[0], 12'hD4D);
      chk("plan_wr_data", act_data[0], 8'hAA);
    end
    verify("wr_aa");

    // Abort after 5 address bits, then a full write.
    drive_req(1, 12'h123, 8'h55, 5, 0, 0); settle(14); verify("abort_addr");
    drive_req(1, 12'h123, 8'h55, 15, 0, 0); settle(14); verify("abort_data");
    drive_req(1, 12'h123, 8'h66, 0, 0, 0); settle(14); verify("after_abort");

    // Back-to-back: write, read same address, then another write, no idle gaps.
    drive_req(1, 12'hD4D, 8'h5A, 0, 0, 1);
    drive_req(0, 12'hD4D, 8'h00, 0, 0, 10);
    drive_req(1, 12'h0F0, 8'hC3, 0, 0, 1);
    drive_req(0, 12'h0F0, 8'h00, 0, 0, 0);
    settle(14); verify("b2b");

    // smode changes after the first cycle must be ignored.
    drive_req(0, 12'h321, 8'h00, 0, 1, 0); settle(14); verify("hold_rd");
    drive_req(1, 12'h321, 8'h99, 0, 1, 0); settle(14); verify("hold_wr");

    // Reset in the middle of the read response.
    drive_req(0, 12'hD4D, 8'h00, 0, 0, 4);
    void'(exp_rd.pop_back());
    rstn = 1'b0;
    #1;
    chk_zero("reset_mid");
    settle(3);
    rstn = 1'b1;
    settle(2);
    verify("reset_mid_log");
    drive_req(1, 12'h456, 8'h3E, 0, 0, 0); settle(14);
    drive_req(0, 12'h456, 8'h00, 0, 0, 0); settle(14); verify("after_reset");

    // Random traffic over a small address pool so reads hit earlier writes.
    pool[0] = 12'hD4D; pool[1] = 12'h000; pool[2] = 12'hFFF; pool[3] = 12'($urandom);
    for (int t = 0; t < 24; t++) begin
      m  = 1'($urandom);
      a  = pool[$urandom_range(0, 3)];
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, m ? 19 : 11) : 0;
      drive_req(m, a, 8'($urandom), ab, ($urandom_range(0, 2) == 0), 0);
      settle(14);
      verify("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
